// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO stream reader.
package fifo_stream_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Number of words held in the output buffer for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_e occ);
    logic [1:0] cnt;
    case (occ)
      OCC_EMPTY: cnt = 2'd0;
      OCC_ONE:   cnt = 2'd1;
      OCC_TWO:   cnt = 2'd2;
      default:   cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry head/tail output buffer. The head entry drives the stream; a
// pushed word lands at the tail after any pop from the head in that cycle.
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output occ_e                  occ
);

  occ_e                  occ_r;
  occ_e                  occ_next_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] head_next_s;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [DATA_WIDTH-1:0] tail_next_s;
  logic                  valid_r;

  // Next occupancy and entry contents from push/pop/flush.
  always_comb begin
    occ_next_s  = occ_r;
    head_next_s = head_r;
    tail_next_s = tail_r;
    if (flush) begin
      occ_next_s  = OCC_EMPTY;
      head_next_s = {DATA_WIDTH{1'b0}};
      tail_next_s = {DATA_WIDTH{1'b0}};
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          // A pop cannot occur here because valid is low.
          if (push) begin
            head_next_s = push_data;
            occ_next_s  = OCC_ONE;
          end else begin
            occ_next_s  = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_next_s = push_data;
            occ_next_s  = OCC_ONE;
          end else if (push) begin
            tail_next_s = push_data;
            occ_next_s  = OCC_TWO;
          end else if (pop) begin
            occ_next_s  = OCC_EMPTY;
          end else begin
            occ_next_s  = OCC_ONE;
          end
        end
        OCC_TWO: begin
          // Push without pop is excluded by the read-issue logic upstream.
          if (pop) begin
            head_next_s = tail_r;
            if (push) begin
              tail_next_s = push_data;
              occ_next_s  = OCC_TWO;
            end else begin
              occ_next_s  = OCC_ONE;
            end
          end else begin
            occ_next_s = OCC_TWO;
          end
        end
        default: begin
          occ_next_s  = OCC_EMPTY;
          head_next_s = {DATA_WIDTH{1'b0}};
          tail_next_s = {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Buffer state registers; valid is registered from the next occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_r   <= OCC_EMPTY;
      head_r  <= {DATA_WIDTH{1'b0}};
      tail_r  <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else begin
      occ_r   <= occ_next_s;
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      valid_r <= (occ_next_s != OCC_EMPTY);
    end
  end

  assign valid = valid_r;
  assign head  = head_r;
  assign occ   = occ_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port (1-cycle read latency) into a valid/ready stream,
// keeping one word per cycle by allowing up to two words buffered or in flight.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic                 pend_r;
  logic [CNT_WIDTH-1:0] words_out_r;
  logic                 pop_s;
  logic                 push_s;
  logic                 read_en_s;
  logic [2:0]           in_flight_s;
  occ_e                 occ_s;

  // Handshake, capture and read-issue decisions for this cycle.
  always_comb begin
    pop_s       = m_valid && m_ready;
    // A word arriving in a flush cycle is discarded rather than captured.
    push_s      = pend_r && !flush;
    // Words that will be buffered or in flight after this cycle's pop;
    // pop implies a non-empty buffer so this never underflows.
    in_flight_s = {1'b0, occ_count(occ_s)} + {2'b00, pend_r} - {2'b00, pop_s};
    if (reset && !fifo_empty && !flush && (in_flight_s < 3'd2)) begin
      read_en_s = 1'b1;
    end else begin
      read_en_s = 1'b0;
    end
  end

  // Remember that a read was accepted so its data is captured next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= read_en_s;
    end
  end

  // Delivered-word counter; wraps naturally and survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_out_r <= {CNT_WIDTH{1'b0}};
    end else if (pop_s) begin
      words_out_r <= words_out_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      words_out_r <= words_out_r;
    end
  end

  fifo_stream_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .push_data(fifo_data),
    .pop      (pop_s),
    .flush    (flush),
    .valid    (m_valid),
    .head     (m_data),
    .occ      (occ_s)
  );

  assign fifo_read_en = read_en_s;
  assign words_out    = words_out_r;

endmodule
